// File: rtl/genpad_pkg.sv
// Shared types and constants for the Genesis/SMS multi-pad reader.
// Holds the pad-type enum, decoded-button bit indices, raw-pin bit indices,
// the scan FSM state enum and the scan phase count.
// Build option: GENPAD_6BTN_EN selects 8-phase scans with 6-button detection;
// without it scans are 4 phases and pads never report 6-button.
package genpad_pkg;

  // Reported pad type
  typedef enum logic [1:0] {
    PAD_SMS  = 2'b00,
    PAD_3BTN = 2'b01,
    PAD_6BTN = 2'b10
  } pad_type_e;

  // Bit positions in the 12-bit decoded word {Z,Y,X,M,S,C,B,A,U,D,L,R}
  localparam int unsigned BTN_R  = 0;
  localparam int unsigned BTN_L  = 1;
  localparam int unsigned BTN_D  = 2;
  localparam int unsigned BTN_U  = 3;
  localparam int unsigned BTN_A  = 4;
  localparam int unsigned BTN_B  = 5;
  localparam int unsigned BTN_C  = 6;
  localparam int unsigned BTN_S  = 7;
  localparam int unsigned BTN_M  = 8;
  localparam int unsigned BTN_X  = 9;
  localparam int unsigned BTN_Y  = 10;
  localparam int unsigned BTN_Z  = 11;
  localparam int unsigned N_BTNS = 12;

  // Bit positions in the 6-bit raw pad bus {C/Start, B/A, Up/Z, Down/Y, Left/X, Right/Mode}
  localparam int unsigned RAW_RM = 0;
  localparam int unsigned RAW_LX = 1;
  localparam int unsigned RAW_DY = 2;
  localparam int unsigned RAW_UZ = 3;
  localparam int unsigned RAW_BA = 4;
  localparam int unsigned RAW_CS = 5;
  localparam int unsigned RAW_W  = 6;

  // Scan FSM states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GAP  = 2'b01,
    SCAN = 2'b10
  } fsm_state_e;

`ifdef GENPAD_6BTN_EN
  localparam int unsigned N_PHASES = 8;
`else
  localparam int unsigned N_PHASES = 4;
`endif

endpackage

// File: rtl/genpad_port_decoder.sv
// Per-port front end: 2-flop synchronizer on the raw pad pins, phase sample
// capture and type/button decode, committed to the outputs on a strobe.
// Ports:
//   fpga_clk_50 - clock
//   nreset      - synchronous active-high reset
//   pad_raw     - raw active-low pad pins {C/Start, B/A, Up/Z, Down/Y, Left/X, Right/Mode}
//   sample      - high on the last cycle of a scan phase
//   phase       - current scan phase index
//   commit      - one-cycle strobe: load decoded results into the outputs
//   pad_type    - registered pad type (00 SMS, 01 3-button, 10 6-button)
//   decoded     - registered active-high buttons {Z,Y,X,M,S,C,B,A,U,D,L,R}
// Build option: GENPAD_6BTN_EN adds phase 5/6 capture and 6-button decode.
module genpad_port_decoder
  import genpad_pkg::*;
(
  input  logic        fpga_clk_50,
  input  logic        nreset,
  input  logic [5:0]  pad_raw,
  input  logic        sample,
  input  logic [2:0]  phase,
  input  logic        commit,
  output logic [1:0]  pad_type,
  output logic [11:0] decoded
);

  logic [RAW_W-1:0]  sync1;
  logic [RAW_W-1:0]  sync2;
  logic [RAW_W-1:0]  s0;       // phase 0: C,B,U,D,L,R
  logic [1:0]        s1_sa;    // phase 1: {Start, A}
  logic              s1_gen;   // phase 1: L and R forced low -> Genesis pad
`ifdef GENPAD_6BTN_EN
  logic              s5_six;   // phase 5: U,D,L,R all low -> 6-button pad
  logic [3:0]        s6_ext;   // phase 6: {Z,Y,X,M}
`endif
  pad_type_e         type_c;
  logic [N_BTNS-1:0] decoded_c;

  // Synchronizer, phase capture and output commit
  always_ff @(posedge fpga_clk_50) begin
    if (nreset) begin
      sync1    <= '1;
      sync2    <= '1;
      s0       <= '1;
      s1_sa    <= '1;
      s1_gen   <= 1'b0;
`ifdef GENPAD_6BTN_EN
      s5_six   <= 1'b0;
      s6_ext   <= '1;
`endif
      pad_type <= 2'(PAD_SMS);
      decoded  <= '0;
    end else begin
      sync1 <= pad_raw;
      sync2 <= sync1;
      if (sample) begin
        if (phase == 3'd0) s0 <= sync2;
        if (phase == 3'd1) begin
          s1_sa  <= {sync2[RAW_CS], sync2[RAW_BA]};
          s1_gen <= ~sync2[RAW_LX] & ~sync2[RAW_RM];
        end
`ifdef GENPAD_6BTN_EN
        if (phase == 3'd5) s5_six <= (sync2[3:0] == 4'b0000);
        if (phase == 3'd6) s6_ext <= sync2[3:0];
`endif
      end
      if (commit) begin
        pad_type <= 2'(type_c);
        decoded  <= decoded_c;
      end
    end
  end

  // Decode: phase 0 bits are common to all pad types; A/Start need a Genesis
  // pad, the extended row needs a 6-button pad.
  always_comb begin
    type_c           = PAD_SMS;
    decoded_c        = '0;
    decoded_c[BTN_R] = ~s0[RAW_RM];
    decoded_c[BTN_L] = ~s0[RAW_LX];
    decoded_c[BTN_D] = ~s0[RAW_DY];
    decoded_c[BTN_U] = ~s0[RAW_UZ];
    decoded_c[BTN_B] = ~s0[RAW_BA];
    decoded_c[BTN_C] = ~s0[RAW_CS];
    if (s1_gen) begin
      type_c           = PAD_3BTN;
      decoded_c[BTN_A] = ~s1_sa[0];
      decoded_c[BTN_S] = ~s1_sa[1];
`ifdef GENPAD_6BTN_EN
      if (s5_six) begin
        type_c           = PAD_6BTN;
        decoded_c[BTN_M] = ~s6_ext[0];
        decoded_c[BTN_X] = ~s6_ext[1];
        decoded_c[BTN_Y] = ~s6_ext[2];
        decoded_c[BTN_Z] = ~s6_ext[3];
      end
`endif
    end
  end

endmodule

// File: rtl/genesis_multipad_reader.sv
// Genesis/SMS multi-port controller reader. A rising edge on iPOLL starts one
// scan: the shared select line is toggled through N_PHASES phases of
// PHASE_CYC cycles, each port is sampled at the end of every phase, and all
// ports' type/button results are published together with a one-cycle oVALID.
// After each scan the select line idles high for GAP_CYC cycles so 6-button
// pads reset their internal counter; requests arriving meanwhile wait.
// Ports:
//   fpga_clk_50      - 50 MHz clock
//   nreset           - synchronous active-high reset
//   iPOLL            - scan request (rising edge)
//   iGENPAD          - raw active-low pad pins, 6 per port
//   oGENPAD_SELECT   - select line per port (identical)
//   oGENPAD_TYPE     - 2-bit pad type per port
//   oGENPAD_DECODED  - 12-bit active-high buttons per port
//   oVALID           - one-cycle pulse when results update
//   oBUSY            - high while scanning
// Build option: GENPAD_6BTN_EN enables 8-phase scans with 6-button detection.
module genesis_multipad_reader
  import genpad_pkg::*;
#(
  parameter int unsigned N_PORTS   = 2,
  parameter int unsigned PHASE_CYC = 500,
  parameter int unsigned GAP_CYC   = 75000
) (
  input  logic                   fpga_clk_50,
  input  logic                   nreset,
  input  logic                   iPOLL,
  input  logic [N_PORTS*6-1:0]   iGENPAD,
  output logic [N_PORTS-1:0]     oGENPAD_SELECT,
  output logic [N_PORTS*2-1:0]   oGENPAD_TYPE,
  output logic [N_PORTS*12-1:0]  oGENPAD_DECODED,
  output logic                   oVALID,
  output logic                   oBUSY
);

  localparam int unsigned MAX_CYC = (GAP_CYC > PHASE_CYC) ? GAP_CYC : PHASE_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_GAP  = 2'(GAP);
  localparam logic [1:0] ST_SCAN = 2'(SCAN);

  localparam logic [2:0]       LAST_PHASE = 3'(N_PHASES - 1);
  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       phase_q, phase_d;
  logic             sel_q, sel_d;
  logic             pending_q, pending_d;
  logic             busy_q;
  logic             commit_q, commit_d;
  logic             valid_q;
  logic             poll_q, poll_prev;
  logic             poll_rise_c;
  logic             sample_c;

  assign poll_rise_c = poll_q & ~poll_prev;
  assign sample_c    = (state_q == ST_SCAN) && (cnt_q == PHASE_LAST);

  // Next-state logic: phase/gap counting, select pattern, request latch
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    sel_d     = sel_q;
    pending_d = pending_q | poll_rise_c;
    commit_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sel_d = 1'b1;
        if (pending_d) begin
          state_d   = ST_SCAN;
          cnt_d     = '0;
          phase_d   = '0;
          pending_d = 1'b0;
        end
      end
      ST_SCAN: begin
        if (cnt_q == PHASE_LAST) begin
          cnt_d = '0;
          if (phase_q == LAST_PHASE) begin
            state_d  = ST_GAP;
            sel_d    = 1'b1;
            commit_d = 1'b1;
          end else begin
            phase_d = phase_q + 3'd1;
            sel_d   = ~phase_d[0];   // high in even phases
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        sel_d   = 1'b1;
      end
    endcase
  end

  // State register. The poll edge detector tracks iPOLL during reset so a
  // level held across reset is not mistaken for a new request.
  always_ff @(posedge fpga_clk_50) begin
    if (nreset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      phase_q   <= '0;
      sel_q     <= 1'b1;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      commit_q  <= 1'b0;
      valid_q   <= 1'b0;
      poll_q    <= iPOLL;
      poll_prev <= iPOLL;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      sel_q     <= sel_d;
      pending_q <= pending_d;
      busy_q    <= (state_d == ST_SCAN);
      commit_q  <= commit_d;
      valid_q   <= commit_q;
      poll_q    <= iPOLL;
      poll_prev <= poll_q;
    end
  end

  // One decoder per port; all share phase timing and the commit strobe
  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    genpad_port_decoder u_dec (
      .fpga_clk_50 (fpga_clk_50),
      .nreset      (nreset),
      .pad_raw     (iGENPAD[p*6 +: 6]),
      .sample      (sample_c),
      .phase       (phase_q),
      .commit      (commit_q),
      .pad_type    (oGENPAD_TYPE[p*2 +: 2]),
      .decoded     (oGENPAD_DECODED[p*12 +: 12])
    );
  end

  assign oGENPAD_SELECT = {N_PORTS{sel_q}};
  assign oVALID         = valid_q;
  assign oBUSY          = busy_q;

endmodule

// File: tb/tb_genesis_multipad_reader.sv
// Bench for genesis_multipad_reader with shortened phase/gap timing.
// Pads are modelled behaviourally from the select line; expected results come
// from the set of buttons each kind of pad physically has.
// Honours GENPAD_6BTN_EN the same way as the design.
module tb_genesis_multipad_reader;

  localparam int NP = 2;
  localparam int PC = 8;
  localparam int GC = 60;
`ifdef GENPAD_6BTN_EN
  localparam bit SIX_EN = 1'b1;
  localparam int NPH    = 8;
`else
  localparam bit SIX_EN = 1'b0;
  localparam int NPH    = 4;
`endif
  localparam int SCAN_LAT    = NPH * PC + 1;
  localparam int PAD_TIMEOUT = 4 * PC;
  localparam int K_SMS = 0, K_3 = 1, K_6 = 2;

  logic            clk = 1'b0;
  logic            nreset = 1'b1;
  logic            poll = 1'b0;
  logic [NP*6-1:0] pad_bus = '1;
  logic [NP-1:0]   sel_out;
  logic [NP*2-1:0] type_out;
  logic [NP*12-1:0] dec_out;
  logic            valid;
  logic            busy;

  always #10 clk = ~clk;

  genesis_multipad_reader #(.N_PORTS(NP), .PHASE_CYC(PC), .GAP_CYC(GC)) dut (
    .fpga_clk_50     (clk),
    .nreset          (nreset),
    .iPOLL           (poll),
    .iGENPAD         (pad_bus),
    .oGENPAD_SELECT  (sel_out),
    .oGENPAD_TYPE    (type_out),
    .oGENPAD_DECODED (dec_out),
    .oVALID          (valid),
    .oBUSY           (busy)
  );

  int checks = 0;
  int failures = 0;
  int valid_count = 0;

  int          pad_kind [NP];
  logic [11:0] pad_btn  [NP];
  int          falls    [NP];
  int          high_run [NP];
  logic        prev_sel [NP];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Raw pins a pad of the given kind presents for the current select level
  function automatic logic [5:0] pad_out(input int kind, input logic [11:0] b,
                                         input logic sel, input int nf);
    if (kind == K_SMS) return ~{b[6], b[5], b[3], b[2], b[1], b[0]};
    if (sel) begin
      if (kind == K_6 && nf == 3) return ~{b[6], b[5], b[11], b[10], b[9], b[8]};
      return ~{b[6], b[5], b[3], b[2], b[1], b[0]};
    end
    if (kind == K_6 && nf == 3) return {~b[7], ~b[4], 4'b0000};
    if (kind == K_6 && nf == 4) return {~b[7], ~b[4], 4'b1111};
    return {~b[7], ~b[4], ~b[3], ~b[2], 2'b00};
  endfunction

  function automatic logic [11:0] exp_dec(input int kind, input logic [11:0] b);
    if (kind == K_SMS) return b & 12'h06F;
    if (kind == K_3 || !SIX_EN) return b & 12'h0FF;
    return b;
  endfunction

  function automatic logic [1:0] exp_type(input int kind);
    if (kind == K_SMS) return 2'b00;
    if (kind == K_3 || !SIX_EN) return 2'b01;
    return 2'b10;
  endfunction

  function automatic logic [11:0] rand_btn();
    logic [11:0] b;
    b = 12'($urandom);
    if (b[3] && b[2]) b[2] = 1'b0;   // no pad presses opposite directions together
    if (b[1] && b[0]) b[0] = 1'b0;
    return b;
  endfunction

  // Pad models react half a cycle after the select line moves
  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (prev_sel[p] && !sel_out[p]) falls[p]++;
      if (sel_out[p]) high_run[p]++; else high_run[p] = 0;
      if (high_run[p] >= PAD_TIMEOUT) falls[p] = 0;
      prev_sel[p] = sel_out[p];
      pad_bus[p*6 +: 6] = pad_out(pad_kind[p], pad_btn[p], sel_out[p], falls[p]);
    end
  end

  always @(posedge clk) if (valid) valid_count <= valid_count + 1;

  task automatic check_outputs(input string tag);
    for (int p = 0; p < NP; p++) begin
      check($sformatf("%s_type%0d", tag, p), 32'(type_out[p*2 +: 2]), 32'(exp_type(pad_kind[p])));
      check($sformatf("%s_dec%0d", tag, p), 32'(dec_out[p*12 +: 12]),
            32'(exp_dec(pad_kind[p], pad_btn[p])));
    end
  endtask

  task automatic start_poll();
    int n;
    @(negedge clk) poll = 1'b1;
    n = 0;
    while (!busy && n < 40) begin @(negedge clk); n++; end
    poll = 1'b0;
    check("scan_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!valid && n < limit) begin @(negedge clk); n++; end
  endtask

  task automatic do_scan(input string tag);
    int n;
    start_poll();
    wait_valid(SCAN_LAT + 20, n);
    check({tag, "_lat"}, 32'(n), 32'(SCAN_LAT));
    check_outputs(tag);
    @(negedge clk);
    check({tag, "_vpulse"}, 32'(valid), 32'd0);
  endtask

  task automatic set_pad(input int p, input int kind, input logic [11:0] b);
    pad_kind[p] = kind;
    pad_btn[p]  = b;
  endtask

  initial begin
    int n, run, vc0, busy_seen;
    for (int p = 0; p < NP; p++) begin
      pad_kind[p] = K_3; pad_btn[p] = '0; falls[p] = 0; high_run[p] = 0; prev_sel[p] = 1'b1;
    end
    repeat (3) @(negedge clk);
    check("rst_sel", 32'(sel_out), 32'({NP{1'b1}}));
    check("rst_type", 32'(type_out), 32'd0);
    check("rst_dec", 32'(dec_out), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    nreset = 1'b0;
    repeat (PAD_TIMEOUT + 2) @(negedge clk);

    // 3-button A+Start, 6-button X+Z
    set_pad(0, K_3, 12'h090);
    set_pad(1, K_6, 12'hA00);
    do_scan("d1");
    repeat (GC + 10) @(negedge clk);

    // SMS button1+Up; then a request during the gap waits it out
    set_pad(0, K_SMS, 12'h028);
    do_scan("d2");
    vc0 = valid_count;
    repeat (4) @(negedge clk);
    poll = 1'b1; repeat (2) @(negedge clk); poll = 1'b0;
    repeat (3) @(negedge clk);
    poll = 1'b1; repeat (2) @(negedge clk); poll = 1'b0;
    run = 12;   // select has been high since one cycle before oVALID
    while (sel_out[0] && run < GC + PC + 40) begin @(negedge clk); run++; end
    check("gap_hold", 32'((run >= GC + PC) && (run <= GC + PC + 4)), 32'd1);
    wait_valid(SCAN_LAT + 20, n);
    check("gap_scan_done", 32'(valid), 32'd1);
    check_outputs("gap");
    repeat (GC + 10) @(negedge clk);
    check("gap_one_valid", 32'(valid_count - vc0), 32'd1);

    // Random pads
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < NP; p++) set_pad(p, int'($urandom_range(0, 2)), rand_btn());
      do_scan($sformatf("r%0d", i));
      repeat (GC + 10) @(negedge clk);
    end

    // Hot swap 6-button -> 3-button on port 0
    set_pad(0, K_6, 12'hF11);
    do_scan("sw6");
    repeat (GC + 10) @(negedge clk);
    set_pad(0, K_3, 12'hF11);
    do_scan("sw3");
    check("sw3_hi", 32'(dec_out[11:8]), 32'd0);
    repeat (GC + 10) @(negedge clk);

    // Reset in the middle of a scan
    vc0 = valid_count;
    start_poll();
    repeat (2 * PC) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    nreset = 1'b0;
    check("mrst_sel", 32'(sel_out), 32'({NP{1'b1}}));
    check("mrst_type", 32'(type_out), 32'd0);
    check("mrst_dec", 32'(dec_out), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    busy_seen = 0;
    for (int c = 0; c < SCAN_LAT + GC + 10; c++) begin
      @(negedge clk);
      if (busy) busy_seen = 1;
    end
    check("mrst_no_valid", 32'(valid_count - vc0), 32'd0);
    check("mrst_no_rescan", 32'(busy_seen), 32'd0);

    set_pad(1, K_SMS, 12'h041);
    do_scan("post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/genesis_multipad_reader.md
GENESIS_MULTIPAD_READER -- requirements
Module: genesis_multipad_reader

Interface
REQ-001 SHALL have parameter N_PORTS, default 2: number of independent Genesis/SMS controller ports (1..4).
REQ-002 SHALL have parameter PHASE_CYC, default 500: clock cycles per select half-period (10 us); legal minimum 4.
REQ-003 SHALL have parameter GAP_CYC, default 75000: minimum select-high idle cycles between scans (1.5 ms, 6-button counter expiry).
REQ-004 SHALL have port fpga_clk_50, input, 1 bit: 50 MHz clock.
REQ-005 SHALL have port nreset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port iPOLL, input, 1 bit: scan request; rising edge requests one scan (typically VSync).
REQ-007 SHALL have port iGENPAD, input, N_PORTS*6 bits: per port {C/Start, B/A, Up/Z, Down/Y, Left/X, Right/Mode}, active-low, asynchronous.
REQ-008 SHALL have port oGENPAD_SELECT, output, N_PORTS bits: select line per port, all ports driven identically.
REQ-009 SHALL have port oGENPAD_TYPE, output, N_PORTS*2 bits: per port 00 SMS, 01 3-button, 10 6-button.
REQ-010 SHALL have port oGENPAD_DECODED, output, N_PORTS*12 bits: per port {Z,Y,X,M,S,C,B,A,U,D,L,R}, active-high pressed.
REQ-011 SHALL have port oVALID, output, 1 bit: one-cycle pulse when all outputs update.
REQ-012 SHALL have port oBUSY, output, 1 bit: high while a scan is in progress.

Function
REQ-013 SHALL pass every iGENPAD bit through a 2-flop synchronizer before use.
REQ-014 SHALL register iPOLL and detect rising edges; at most one request pending, further edges dropped.
REQ-015 SHALL use FSM states IDLE, GAP, SCAN; IDLE->SCAN on pending request; SCAN->GAP after last phase; GAP->IDLE after GAP_CYC cycles.
REQ-016 SHALL run SCAN as 8 phases of PHASE_CYC cycles each; select = 1 in even phases, 0 in odd phases; select = 1 in IDLE/GAP.
REQ-017 SHALL sample synchronized inputs on the last cycle of each phase.
REQ-018 Phase 0 sample: C,B,U,D,L,R; phase 1 sample: S,A, and L,R both low marks Genesis pad, otherwise SMS.
REQ-019 Phase 5 sample with U,D,L,R all low marks 6-button; phase 6 sample: C,B,Z,Y,X,M.
REQ-020 SMS port: decoded bits 6:5 and 3:0 from phase 0; bits 11:7 and 4 SHALL be 0.
REQ-021 3-button port: bits 11:8 SHALL be 0.
REQ-022 SHALL update oGENPAD_TYPE and oGENPAD_DECODED for all ports atomically, with oVALID high, one cycle after phase 7 ends: 8*PHASE_CYC+1 cycles after scan start.
REQ-023 A request arriving during SCAN or GAP SHALL be held pending and serviced on entry to IDLE, with no select edge within GAP.
REQ-024 Type is re-detected every scan; a hot-swapped pad SHALL report its new type at the next oVALID.

Reset
REQ-025 While nreset is high: FSM=IDLE, counters=0, pending=0, oGENPAD_SELECT all 1, oGENPAD_TYPE all 00, oGENPAD_DECODED all 0, oVALID=0, oBUSY=0.
REQ-026 Reset mid-scan SHALL abort with no oVALID and no output update; the next scan starts only after a new iPOLL edge.

Configuration
REQ-027 With GENPAD_6BTN_EN defined, scan SHALL be 8 phases with 6-button detection.
REQ-028 Without GENPAD_6BTN_EN, scan SHALL be 4 phases (oVALID at 4*PHASE_CYC+1), type never 10, bits 11:8 always 0.

Structure
REQ-029 Package genpad_pkg SHALL hold the pad-type enum, 12 button bit-index constants, and the FSM state enum.
REQ-030 Sub-module genpad_port_decoder SHALL hold per-port synchronizer, phase samples and decode; it SHALL be instantiated N_PORTS times by generate.

Verification (defaults, GENPAD_6BTN_EN defined)
REQ-031 Port0 3-button with A+Start pressed, iPOLL edge -> oVALID after 4001 cycles; TYPE0=01; DECODED0=12'h090.
REQ-032 Port1 6-button with X+Z pressed, port0 SMS with button1+Up -> TYPE1=10, DECODED1=12'hA00; TYPE0=00, DECODED0=12'h028.
REQ-033 Second iPOLL 100 cycles after scan end -> select stays 1 for 75000 cycles, then the scan runs; exactly one oVALID.
REQ-034 nreset pulsed at cycle 2000 of a scan -> no oVALID; outputs 0 and select 1 on the next cycle.
REQ-035 Port0 pad swapped from 6-button to 3-button between scans -> TYPE0 changes 10->01 at the next oVALID; bits 11:8 become 0.
REQ-036 Build without GENPAD_6BTN_EN, 6-button pad attached -> TYPE=01, oVALID at 2001 cycles, bits 11:8 = 0.
